// File: rtl/board_cell_reader.sv
// Read-side sequencer for the board data memory: scans every cell once per START
// and presents it on a valid/ready stream. Optional SKIP_EMPTY_EN drops zero cells.
module board_cell_reader #(
    parameter int NUM_CELLS  = 36,
    parameter int EDGE_CELLS = 24,
    parameter int CELL_W     = 4,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              START,
    input  logic              ABORT,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [CELL_W-1:0] MEM_DATA,
    output logic              CELL_VALID,
    input  logic              CELL_READY,
    output logic [CELL_W-1:0] CELL_DATA,
    output logic [ADDR_W-1:0] CELL_INDEX,
    output logic              IS_CENTER,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;
    localparam logic [1:0] S_FINISH  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CELLS - 1);
    localparam logic [ADDR_W-1:0] EDGE_IDX = ADDR_W'(EDGE_CELLS);

    logic [1:0]        state;
    logic [ADDR_W-1:0] index;
    logic              skip;

    // The memory address is the scan index itself, so it is registered and
    // can never leave 0..NUM_CELLS-1.
    assign MEM_ADDR = index;

`ifdef SKIP_EMPTY_EN
    assign skip = (MEM_DATA == '0);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            index      <= '0;
            CELL_VALID <= 1'b0;
            CELL_DATA  <= '0;
            CELL_INDEX <= '0;
            IS_CENTER  <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state <= S_FETCH;
                        index <= '0;
                        BUSY  <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (ABORT) begin
                        state      <= S_IDLE;
                        index      <= '0;
                        CELL_VALID <= 1'b0;
                        DONE       <= 1'b0;
                        BUSY       <= 1'b0;
                    end else if (skip) begin
                        if (index == LAST_IDX) begin
                            state <= S_FINISH;
                            DONE  <= 1'b1;
                        end else begin
                            index <= index + ADDR_W'(1);
                        end
                    end else begin
                        CELL_DATA  <= MEM_DATA;
                        CELL_INDEX <= index;
                        IS_CENTER  <= (index >= EDGE_IDX);
                        CELL_VALID <= 1'b1;
                        state      <= S_PRESENT;
                    end
                end

                S_PRESENT: begin
                    // ABORT wins over a transfer in the same cycle
                    if (ABORT) begin
                        state      <= S_IDLE;
                        index      <= '0;
                        CELL_VALID <= 1'b0;
                        DONE       <= 1'b0;
                        BUSY       <= 1'b0;
                    end else if (CELL_READY) begin
                        CELL_VALID <= 1'b0;
                        if (index == LAST_IDX) begin
                            state <= S_FINISH;
                            DONE  <= 1'b1;
                        end else begin
                            index <= index + ADDR_W'(1);
                            state <= S_FETCH;
                        end
                    end
                end

                S_FINISH: begin
                    state <= S_IDLE;
                    index <= '0;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                end

                default: begin
                    state      <= S_IDLE;
                    index      <= '0;
                    CELL_VALID <= 1'b0;
                    DONE       <= 1'b0;
                    BUSY       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_cell_reader.sv
// Scoreboard bench for board_cell_reader: expected cells are queued at START and
// compared at every accepted transfer; per-scenario tasks check timing and control.
module tb_board_cell_reader;

    localparam int NUM_CELLS  = 36;
    localparam int EDGE_CELLS = 24;
    localparam int CELL_W     = 4;
    localparam int ADDR_W     = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              START;
    logic              ABORT;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [CELL_W-1:0] MEM_DATA;
    logic              CELL_VALID;
    logic              CELL_READY;
    logic [CELL_W-1:0] CELL_DATA;
    logic [ADDR_W-1:0] CELL_INDEX;
    logic              IS_CENTER;
    logic              BUSY;
    logic              DONE;

    logic [CELL_W-1:0] mem [0:63];
    assign MEM_DATA = mem[MEM_ADDR];

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic [CELL_W-1:0] data;
        logic              ctr;
    } cell_t;

    cell_t exp_q[$];
    cell_t mon_e;
    int pass_cnt = 0;
    int total_cnt = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;

    board_cell_reader #(
        .NUM_CELLS(NUM_CELLS), .EDGE_CELLS(EDGE_CELLS), .CELL_W(CELL_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .START(START), .ABORT(ABORT),
        .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
        .CELL_VALID(CELL_VALID), .CELL_READY(CELL_READY),
        .CELL_DATA(CELL_DATA), .CELL_INDEX(CELL_INDEX), .IS_CENTER(IS_CENTER),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 clk = ~clk;

    // Transfers are judged mid-cycle, while inputs driven after the rising edge are stable.
    always @(negedge clk) begin
        if (!rst && CELL_VALID && CELL_READY && !ABORT) begin
            xfer_cnt++;
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL xfer_unexpected: got index=%0d data=%0d, expected no transfer",
                         CELL_INDEX, CELL_DATA);
            end else begin
                mon_e = exp_q.pop_front();
                if (CELL_INDEX !== mon_e.idx || CELL_DATA !== mon_e.data || IS_CENTER !== mon_e.ctr)
                    $display("FAIL xfer: got idx=%0d data=%0d ctr=%0b, expected idx=%0d data=%0d ctr=%0b",
                             CELL_INDEX, CELL_DATA, IS_CENTER, mon_e.idx, mon_e.data, mon_e.ctr);
                else
                    pass_cnt++;
            end
        end
        if (!rst && DONE) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pass();
        cell_t c;
        for (int i = 0; i < NUM_CELLS; i++) begin
`ifdef SKIP_EMPTY_EN
            if (mem[i] == '0) continue;
`endif
            c.idx  = ADDR_W'(i);
            c.data = mem[i];
            c.ctr  = (i >= EDGE_CELLS);
            exp_q.push_back(c);
        end
    endtask

    task automatic pulse_start();
        START = 1'b1;
        push_pass();
        tick();
        START = 1'b0;
    endtask

    task automatic wait_cell(input int idx);
        int n = 0;
        while (!(CELL_VALID && CELL_INDEX == ADDR_W'(idx)) && n < 200) begin
            tick();
            n++;
        end
        total_cnt++;
        if (n >= 200) $display("FAIL wait_cell: timeout waiting for index %0d", idx);
        else pass_cnt++;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!DONE && n < 300) begin
            tick();
            n++;
        end
        total_cnt++;
        if (!DONE) $display("FAIL wait_done: timeout, DONE=%0b expected 1", DONE);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; START = 1'b0; ABORT = 1'b0; CELL_READY = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        #12;
        total_cnt++;
        if ({CELL_VALID, IS_CENTER, BUSY, DONE, MEM_ADDR, CELL_DATA, CELL_INDEX} !== '0)
            $display("FAIL reset_outputs: got valid=%0b ctr=%0b busy=%0b done=%0b addr=%0d data=%0d idx=%0d, expected all 0",
                     CELL_VALID, IS_CENTER, BUSY, DONE, MEM_ADDR, CELL_DATA, CELL_INDEX);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        tick();
        total_cnt++;
        if (BUSY !== 1'b0) $display("FAIL reset_idle: got busy=%0b expected 0", BUSY);
        else pass_cnt++;
    endtask

    task automatic test_full_pass();
        int n;
        for (int i = 0; i < NUM_CELLS; i++) mem[i] = CELL_W'(i % 16);
        CELL_READY = 1'b1; xfer_cnt = 0; done_cnt = 0;
        pulse_start();
        total_cnt++;
        if (BUSY !== 1'b1 || CELL_VALID !== 1'b0)
            $display("FAIL latency_fetch: got busy=%0b valid=%0b, expected busy=1 valid=0", BUSY, CELL_VALID);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (CELL_VALID !== 1'b1 || CELL_INDEX !== '0)
            $display("FAIL latency_first: got valid=%0b idx=%0d, expected valid=1 idx=0", CELL_VALID, CELL_INDEX);
        else pass_cnt++;
        n = 1;
        while (!DONE && n < 300) begin
            tick();
            n++;
        end
        total_cnt++;
        if (n != 72 || BUSY !== 1'b1)
            $display("FAIL pass_timing: got done after %0d cycles busy=%0b, expected 72 busy=1", n, BUSY);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (DONE !== 1'b0 || BUSY !== 1'b0)
            $display("FAIL done_pulse: got done=%0b busy=%0b, expected 0 0", DONE, BUSY);
        else pass_cnt++;
        total_cnt++;
        if (xfer_cnt != 36 || done_cnt != 1 || exp_q.size() != 0)
            $display("FAIL full_pass_count: got xfers=%0d dones=%0d left=%0d, expected 36 1 0",
                     xfer_cnt, done_cnt, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        xfer_cnt = 0; done_cnt = 0;
        pulse_start();
        wait_cell(7);
        CELL_READY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total_cnt++;
            if (CELL_VALID !== 1'b1 || CELL_INDEX !== 6'd7 || CELL_DATA !== 4'd7)
                $display("FAIL stall_hold: got valid=%0b idx=%0d data=%0d, expected 1 7 7",
                         CELL_VALID, CELL_INDEX, CELL_DATA);
            else pass_cnt++;
        end
        CELL_READY = 1'b1;
        tick();
        wait_cell(8);
        wait_done();
        tick();
        total_cnt++;
        if (xfer_cnt != 36 || done_cnt != 1 || exp_q.size() != 0)
            $display("FAIL stall_count: got xfers=%0d dones=%0d left=%0d, expected 36 1 0",
                     xfer_cnt, done_cnt, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_abort();
        xfer_cnt = 0; done_cnt = 0;
        pulse_start();
        wait_cell(20);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        total_cnt++;
        if (CELL_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || MEM_ADDR !== '0)
            $display("FAIL abort_idle: got valid=%0b busy=%0b done=%0b addr=%0d, expected 0 0 0 0",
                     CELL_VALID, BUSY, DONE, MEM_ADDR);
        else pass_cnt++;
        total_cnt++;
        if (xfer_cnt != 20 || exp_q.size() == 0 || exp_q[0].idx !== 6'd20)
            $display("FAIL abort_xfers: got xfers=%0d left=%0d, expected 20 transfers with cell 20 pending",
                     xfer_cnt, exp_q.size());
        else pass_cnt++;
        exp_q.delete();
        for (int k = 0; k < 4; k++) tick();
        total_cnt++;
        if (done_cnt != 0 || BUSY !== 1'b0)
            $display("FAIL abort_no_done: got dones=%0d busy=%0b, expected 0 0", done_cnt, BUSY);
        else pass_cnt++;
        ABORT = 1'b1;
        tick();
        total_cnt++;
        if (BUSY !== 1'b0) $display("FAIL abort_in_idle: got busy=%0b expected 0", BUSY);
        else pass_cnt++;
        xfer_cnt = 0;
        pulse_start();
        ABORT = 1'b0;
        total_cnt++;
        if (BUSY !== 1'b1) $display("FAIL start_beats_abort: got busy=%0b expected 1", BUSY);
        else pass_cnt++;
        wait_done();
        tick();
        total_cnt++;
        if (xfer_cnt != 36 || done_cnt != 1 || exp_q.size() != 0)
            $display("FAIL restart_count: got xfers=%0d dones=%0d left=%0d, expected 36 1 0",
                     xfer_cnt, done_cnt, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        xfer_cnt = 0; done_cnt = 0;
        pulse_start();
        wait_cell(10);
        START = 1'b1;
        tick();
        tick();
        START = 1'b0;
        wait_done();
        START = 1'b1;
        tick();
        START = 1'b0;
        total_cnt++;
        if (BUSY !== 1'b0 || DONE !== 1'b0)
            $display("FAIL start_at_done: got busy=%0b done=%0b, expected 0 0", BUSY, DONE);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (xfer_cnt != 36 || done_cnt != 1 || exp_q.size() != 0 || BUSY !== 1'b0)
            $display("FAIL start_ignored_count: got xfers=%0d dones=%0d left=%0d busy=%0b, expected 36 1 0 0",
                     xfer_cnt, done_cnt, exp_q.size(), BUSY);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        pulse_start();
        wait_cell(3);
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({CELL_VALID, IS_CENTER, BUSY, DONE, MEM_ADDR, CELL_DATA, CELL_INDEX} !== '0)
            $display("FAIL async_reset: got valid=%0b busy=%0b addr=%0d data=%0d idx=%0d, expected all 0",
                     CELL_VALID, BUSY, MEM_ADDR, CELL_DATA, CELL_INDEX);
        else pass_cnt++;
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        total_cnt++;
        if (BUSY !== 1'b0 || CELL_VALID !== 1'b0)
            $display("FAIL post_reset_idle: got busy=%0b valid=%0b, expected 0 0", BUSY, CELL_VALID);
        else pass_cnt++;
    endtask

`ifdef SKIP_EMPTY_EN
    task automatic test_skip_empty();
        int n;
        for (int i = 0; i < NUM_CELLS; i++) mem[i] = '0;
        mem[3] = 4'd5; mem[24] = 4'd9; mem[35] = 4'd1;
        xfer_cnt = 0; done_cnt = 0;
        pulse_start();
        wait_done();
        tick();
        total_cnt++;
        if (xfer_cnt != 3 || done_cnt != 1 || exp_q.size() != 0)
            $display("FAIL skip_sparse: got xfers=%0d dones=%0d left=%0d, expected 3 1 0",
                     xfer_cnt, done_cnt, exp_q.size());
        else pass_cnt++;
        mem[3] = '0; mem[24] = '0; mem[35] = '0;
        xfer_cnt = 0; done_cnt = 0;
        pulse_start();
        n = 0;
        while (!DONE && n < 300) begin
            tick();
            n++;
        end
        tick();
        total_cnt++;
        if (n != 36 || xfer_cnt != 0 || done_cnt != 1)
            $display("FAIL skip_all_zero: got done after %0d cycles xfers=%0d dones=%0d, expected 36 0 1",
                     n, xfer_cnt, done_cnt);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_full_pass();
        test_backpressure();
        test_abort();
        test_start_ignored();
        test_async_reset();
`ifdef SKIP_EMPTY_EN
        test_skip_empty();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
